// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one memory port between an instruction-fetch and a data requester
module unified_mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ack,
   output logic        i_err,
   input  logic        d_req,
   input  logic        d_write,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        d_err,
   output logic [31:0] MAD,
   output logic        MREQ,
   output logic        MWRITE,
   output logic [1:0]  MSIZE,
   output logic [31:0] MWDT,
   input  logic [31:0] MRDT,
   input  logic        ACKM_n
);
   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;
   state_t state, state_n;
   logic last_d, served_d, err_q, mwrite_q, in_grant, pick_d, done;
   logic [7:0] cnt;
   logic [1:0] msize_q;
   logic [31:0] mad_q, mwdt_q;
   assign in_grant = state == GRANT_I || state == GRANT_D;
   assign pick_d = d_req && (!i_req || !last_d);
   assign done = !ACKM_n || (cnt + 8'd1 == 8'(TIMEOUT_CYCLES));
   assign MREQ = in_grant;
   assign MWRITE = mwrite_q & in_grant;
   assign MSIZE = msize_q;
   assign MAD = mad_q;
   assign MWDT = mwdt_q;
   assign i_ack = state == RESP && !served_d;
   assign d_ack = state == RESP && served_d;
   assign i_err = i_ack & err_q;
   assign d_err = d_ack & err_q;
   // next state: arbitrate in IDLE, finish a grant on acknowledge or timeout, RESP lasts one cycle
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = pick_d ? GRANT_D : (i_req ? GRANT_I : IDLE);
         GRANT_I,
         GRANT_D: state_n = done ? RESP : state;
         default: state_n = IDLE;
      endcase
   end
   // state, latched memory command, wait counter and captured read data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         last_d <= 1'b0;
         served_d <= 1'b0;
         err_q <= 1'b0;
         cnt <= '0;
         mad_q <= '0;
         mwrite_q <= 1'b0;
         msize_q <= '0;
         mwdt_q <= '0;
         i_rdata <= '0;
         d_rdata <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && state_n != IDLE) begin
            last_d <= state_n == GRANT_D;
            served_d <= state_n == GRANT_D;
            err_q <= 1'b0;
            cnt <= '0;
            mad_q <= state_n == GRANT_D ? d_addr : i_addr;
            mwrite_q <= state_n == GRANT_D && d_write;
            msize_q <= state_n == GRANT_D ? d_size : 2'b00;
            mwdt_q <= (state_n == GRANT_D && d_write) ? d_wdata : '0;
         end
         if (in_grant) cnt <= cnt + 8'd1;
         if (in_grant && done) begin
            err_q <= ACKM_n;
            if (state == GRANT_D) d_rdata <= (ACKM_n || mwrite_q) ? '0 : MRDT;
            else i_rdata <= ACKM_n ? '0 : MRDT;
         end
      end
   end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: scoreboard bench for the unified memory arbiter
module tb_unified_mem_arbiter;
   logic clk = 0, rst = 1;
   logic i_req = 0, d_req = 0, d_write = 0;
   logic [1:0] d_size = 0;
   logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, mrdt = 0;
   logic ackm_n = 1;
   logic [31:0] i_rdata, d_rdata, MAD, MWDT;
   logic i_ack, i_err, d_ack, d_err, MREQ, MWRITE;
   logic [1:0] MSIZE;
   int checks = 0, failures = 0;
   int ack_delay = 1, mcyc = 0;
   typedef struct {logic d; logic [31:0] rdata; logic err;} rsp_t;
   typedef struct {logic [31:0] mad; logic mwrite; logic [1:0] msize; logic [31:0] mwdt; int len;} gnt_t;
   rsp_t rsp_q[$];
   gnt_t gnt_q[$];

   unified_mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
      .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
      .MAD(MAD), .MREQ(MREQ), .MWRITE(MWRITE), .MSIZE(MSIZE), .MWDT(MWDT),
      .MRDT(mrdt), .ACKM_n(ackm_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push_g(input logic [31:0] mad, input logic mw, input logic [1:0] ms, input logic [31:0] wd, input int len);
      gnt_t g;
      g.mad = mad; g.mwrite = mw; g.msize = ms; g.mwdt = wd; g.len = len;
      gnt_q.push_back(g);
   endtask

   task automatic push_r(input logic d, input logic [31:0] rd, input logic err);
      rsp_t r;
      r.d = d; r.rdata = rd; r.err = err;
      rsp_q.push_back(r);
   endtask

   task automatic wait_ack(input logic d, output int n);
      logic got = 0;
      n = 0;
      while (!got && n < 64) begin
         @(negedge clk);
         n++;
         if (d ? d_ack : i_ack) begin
            got = 1;
            if (d) d_req = 0; else i_req = 0;
         end
      end
      if (!got) chk(d ? "d_ack_timeout" : "i_ack_timeout", 96'd0, 96'd1);
   endtask

   // memory model: acknowledge on the ack_delay-th cycle of a request, never when ack_delay is 0
   always @(negedge clk) begin
      if (rst || !MREQ) begin
         mcyc = 0;
         ackm_n = 1;
      end else begin
         mcyc = mcyc + 1;
         ackm_n = !(ack_delay != 0 && mcyc == ack_delay);
      end
   end

   // monitor: compare every grant and every acknowledge against the scoreboard queues
   initial begin
      gnt_t cur;
      rsp_t r;
      logic prev = 0;
      int glen = 0;
      cur = '{default: '0};
      forever begin
         @(negedge clk);
         if (MWRITE && !MREQ) chk("mwrite_outside_grant", 96'd1, 96'd0);
         if (MREQ) begin
            if (!prev) begin
               glen = 0;
               if (gnt_q.size() == 0) chk("unexpected_grant", {MAD, 64'd0}, 96'd0);
               else cur = gnt_q.pop_front();
            end
            glen++;
            chk("grant_cmd", {29'd0, MAD, MWRITE, MSIZE, MWDT}, {29'd0, cur.mad, cur.mwrite, cur.msize, cur.mwdt});
         end else if (prev && cur.len >= 0) chk("grant_len", 96'(glen), 96'(cur.len));
         prev = MREQ;
         if (i_ack || d_ack) begin
            if (i_ack && d_ack) chk("both_acks", 96'd1, 96'd0);
            if (rsp_q.size() == 0) chk("unexpected_ack", {94'd0, i_ack, d_ack}, 96'd0);
            else begin
               r = rsp_q.pop_front();
               chk("ack_side", {95'd0, d_ack}, {95'd0, r.d});
               chk("ack_rdata", {64'd0, d_ack ? d_rdata : i_rdata}, {64'd0, r.rdata});
               chk("ack_err", {95'd0, d_ack ? d_err : i_err}, {95'd0, r.err});
            end
         end
      end
   end

   // stimulus
   initial begin
      int n, side, got;
      #12;
      chk("reset_outputs", {MREQ, MWRITE, MSIZE, MAD, MWDT, i_ack, d_ack, i_err, d_err}, 96'd0);
      chk("reset_rdata", {32'd0, i_rdata, d_rdata}, 96'd0);
      @(negedge clk); rst = 0;
      // single fetch, minimum latency
      mrdt = 32'h13; ack_delay = 1;
      push_g(32'h100, 0, 2'b00, 0, 1); push_r(0, 32'h13, 0);
      i_addr = 32'h100; i_req = 1;
      wait_ack(0, n);
      chk("fetch_latency", 96'(n), 96'd2);
      // contention from reset: store on D first, then fetch on I
      @(negedge clk); rst = 1; @(negedge clk); rst = 0;
      mrdt = 32'h1234_5678;
      push_g(32'h0800_0000, 1, 2'b00, 32'hDEAD_BEEF, 1); push_r(1, 0, 0);
      push_g(32'h200, 0, 2'b00, 0, 1); push_r(0, 32'h1234_5678, 0);
      d_write = 1; d_size = 2'b00; d_addr = 32'h0800_0000; d_wdata = 32'hDEAD_BEEF; i_addr = 32'h200;
      i_req = 1; d_req = 1;
      wait_ack(1, n);
      wait_ack(0, n);
      // acknowledge on the last wait cycle wins; requester inputs change mid-grant
      @(negedge clk);
      mrdt = 32'hCAFE_F00D; ack_delay = 16;
      push_g(32'h400, 0, 2'b00, 0, 16); push_r(1, 32'hCAFE_F00D, 0);
      d_write = 0; d_addr = 32'h400; d_req = 1;
      repeat (3) @(negedge clk);
      d_addr = 32'hFFFF_FFFF; d_wdata = 32'h5555_5555; d_write = 1;
      wait_ack(1, n);
      d_write = 0;
      // timeout: memory never acknowledges
      @(negedge clk);
      ack_delay = 0;
      push_g(32'h300, 0, 2'b00, 0, 16); push_r(1, 0, 1);
      d_addr = 32'h300; d_req = 1;
      wait_ack(1, n);
      chk("timeout_latency", 96'(n), 96'd17);
      chk("i_rdata_hold", {64'd0, i_rdata}, {64'd0, 32'h1234_5678});
      // byte store
      @(negedge clk);
      ack_delay = 1;
      push_g(32'hF000_0000, 1, 2'b10, 32'h41, 1); push_r(1, 0, 0);
      d_write = 1; d_size = 2'b10; d_addr = 32'hF000_0000; d_wdata = 32'h41; d_req = 1;
      wait_ack(1, n);
      // back-to-back alternation, last grant was D so I goes first
      @(negedge clk);
      mrdt = 32'h77;
      i_addr = 32'h500; d_addr = 32'h600; d_wdata = 32'h66; d_size = 2'b00; d_write = 1;
      push_g(32'h500, 0, 2'b00, 0, 1); push_r(0, 32'h77, 0);
      push_g(32'h600, 1, 2'b00, 32'h66, 1); push_r(1, 0, 0);
      push_g(32'h500, 0, 2'b00, 0, 1); push_r(0, 32'h77, 0);
      push_g(32'h600, 1, 2'b00, 32'h66, 1); push_r(1, 0, 0);
      i_req = 1; d_req = 1;
      for (int k = 0; k < 4; k++) begin
         got = 0;
         side = 0;
         for (int t = 0; t < 40 && got == 0; t++) begin
            @(negedge clk);
            if (i_ack) begin i_req = 0; got = 1; side = 0; end
            else if (d_ack) begin d_req = 0; got = 1; side = 1; end
         end
         if (got == 0) chk("alternate_timeout", 96'd0, 96'd1);
         if (k < 2) begin
            @(negedge clk);
            if (side == 1) d_req = 1; else i_req = 1;
         end
      end
      i_req = 0; d_req = 0; d_write = 0;
      // reset in the middle of a fetch grant
      @(negedge clk);
      ack_delay = 0;
      push_g(32'h700, 0, 2'b00, 0, -1);
      i_addr = 32'h700; i_req = 1;
      repeat (3) @(negedge clk);
      #1 rst = 1;
      #1 chk("rst_mreq_drop", {94'd0, MREQ, i_ack}, 96'd0);
      chk("rst_rdata", {32'd0, i_rdata, d_rdata}, 96'd0);
      @(negedge clk); i_req = 0; rst = 0;
      repeat (2) @(negedge clk);
      ack_delay = 1; mrdt = 32'h99;
      push_g(32'h800, 0, 2'b00, 0, 1); push_r(1, 32'h99, 0);
      d_addr = 32'h800; d_req = 1;
      wait_ack(1, n);
      repeat (4) @(negedge clk);
      chk("queues_drained", 96'(gnt_q.size() + rsp_q.size()), 96'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
